// File: rtl/msdf_feed_seq_pkg.sv
// Shared definitions for the MSDF operand-feed sequencer: FSM encoding,
// default widths and codes, and the slot-counter width helper.
package msdf_feed_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRE    = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_FILL   = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  localparam int DIGIT_W_DEF   = 192;
  localparam int LAST_CODE_DEF = 4;

  localparam logic [DIGIT_W_DEF-1:0] DIGIT_ZERO = '0;

  // Slot counter width; never below one bit so tiny jobs still elaborate.
  function automatic int slotWidth(input int totalDigits);
    return (totalDigits > 2) ? $clog2(totalDigits) : 1;
  endfunction

endpackage

// File: rtl/msdf_feed_seq_if.sv
// Job, input-stream, weight-memory and output-operand signals of the
// feed sequencer bundled as one interface.
interface msdf_feed_seq_if
  import msdf_feed_pkg::*;
#(
  parameter int DIGIT_W = DIGIT_W_DEF,
  parameter int ADDR_W  = 9
);
  logic               start_valid;
  logic [ADDR_W-1:0]  start_base;
  logic               start_ready;
  logic [DIGIT_W-1:0] dataInArray_0;
  logic               pValidArray_0;
  logic               readyArray_0;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_en;
  logic [DIGIT_W-1:0] mem_rdata;
  logic [DIGIT_W-1:0] dataOutArray_0;
  logic [DIGIT_W-1:0] dataOutArray_1;
  logic               lastOut;
  logic               validArray_0;
  logic               nReadyArray_0;
  logic               done;

  modport slave (
    input  start_valid, start_base, dataInArray_0, pValidArray_0, mem_rdata, nReadyArray_0,
    output start_ready, readyArray_0, mem_addr, mem_en, dataOutArray_0, dataOutArray_1,
           lastOut, validArray_0, done
  );

  modport master (
    output start_valid, start_base, dataInArray_0, pValidArray_0, mem_rdata, nReadyArray_0,
    input  start_ready, readyArray_0, mem_addr, mem_en, dataOutArray_0, dataOutArray_1,
           lastOut, validArray_0, done
  );
endinterface

// File: rtl/msdf_feed_pipe.sv
// Stall-able delay line carrying {valid, last, op0} so op0 arrives together
// with the weight word leaving the fixed-latency memory.
module msdf_feed_pipe #(
  parameter int DATA_W = 192,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              inVld,
  input  logic              inLast,
  input  logic [DATA_W-1:0] inOp0,
  output logic              outVld,
  output logic              outLast,
  output logic [DATA_W-1:0] outOp0,
  output logic              anyVld
);

  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] last_p;
  logic [DATA_W-1:0] op0_p [STAGES];

  // Control bits shift on enable and clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p  <= '0;
      last_p <= '0;
    end else if (en) begin
      vld_p[0]  <= inVld;
      last_p[0] <= inLast;
      for (int i = 1; i < STAGES; i++) begin
        vld_p[i]  <= vld_p[i-1];
        last_p[i] <= last_p[i-1];
      end
    end
  end

  // Operand data shifts with the same enable; qualified by vld_p downstream.
  always_ff @(posedge clk) begin
    if (en) begin
      op0_p[0] <= inOp0;
      for (int i = 1; i < STAGES; i++) op0_p[i] <= op0_p[i-1];
    end
  end

  assign outVld  = vld_p[STAGES-1];
  assign outLast = last_p[STAGES-1] & vld_p[STAGES-1];
  assign outOp0  = op0_p[STAGES-1];
  assign anyVld  = |vld_p;

endmodule

// File: rtl/msdf_feed_seq.sv
// Operand-feed sequencer for an MSDF dot unit: per job emits TOTAL_DIGITS
// slots pairing a zero/streamed/last-marker digit with a weight word read
// from base+slot. The whole pipe, including the memory, stalls as one unit.
module msdf_feed_seq
  import msdf_feed_pkg::*;
#(
  parameter int DIGIT_W      = DIGIT_W_DEF,
  parameter int ADDR_W       = 9,
  parameter int PRE_DIGITS   = 4,
  parameter int A_DIGITS     = 3,
  parameter int TOTAL_DIGITS = 25,
  parameter int MEM_LAT      = 2,
  parameter int LAST_CODE    = LAST_CODE_DEF
) (
  input logic          clk,
  input logic          rst,
  msdf_feed_seq_if.slave bus
);

  localparam int SLOT_W = slotWidth(TOTAL_DIGITS);
  localparam logic [SLOT_W-1:0]  SLOT_PRE_END = SLOT_W'(PRE_DIGITS - 1);
  localparam logic [SLOT_W-1:0]  SLOT_A_END   = SLOT_W'(PRE_DIGITS + A_DIGITS - 1);
  localparam logic [SLOT_W-1:0]  SLOT_LAST    = SLOT_W'(TOTAL_DIGITS - 1);
  localparam logic [DIGIT_W-1:0] LAST_WORD    = DIGIT_W'(LAST_CODE);

  logic [2:0]         state;
  logic [SLOT_W-1:0]  slot;
  logic [ADDR_W-1:0]  base;
  logic               adv;
  logic               inject;
  logic               injLast;
  logic [DIGIT_W-1:0] injOp0;
  logic               outVld;
  logic               outLast;
  logic               anyVld;
  logic [DIGIT_W-1:0] outOp0;

  // Everything moves unless a valid output is being held by downstream.
  assign adv = ~outVld | bus.nReadyArray_0;

  // Pick what, if anything, enters the pipe this cycle.
  always_comb begin
    inject  = 1'b0;
    injLast = 1'b0;
    injOp0  = DIGIT_W'(DIGIT_ZERO);
    case (state)
      ST_PRE: inject = adv;
      ST_STREAM: begin
        inject = adv & bus.pValidArray_0;
        injOp0 = bus.dataInArray_0;
      end
      ST_FILL: begin
        inject = adv;
        if (slot == SLOT_LAST) begin
          injLast = 1'b1;
          injOp0  = LAST_WORD;
        end
      end
      default: ;
    endcase
  end

  // Job FSM, slot counter and latched base address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      slot  <= '0;
      base  <= '0;
    end else begin
      if (inject) slot <= slot + SLOT_W'(1);
      case (state)
        ST_IDLE: begin
          if (bus.start_valid) begin
            base  <= bus.start_base;
            slot  <= '0;
            state <= (PRE_DIGITS > 0) ? ST_PRE : ST_STREAM;
          end
        end
        ST_PRE:    if (inject && slot == SLOT_PRE_END) state <= ST_STREAM;
        ST_STREAM: if (inject && slot == SLOT_A_END)   state <= ST_FILL;
        ST_FILL:   if (inject && slot == SLOT_LAST)    state <= ST_FINISH;
        ST_FINISH: if (!anyVld)                        state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  msdf_feed_pipe #(
    .DATA_W (DIGIT_W),
    .STAGES (MEM_LAT)
  ) uPipe (
    .clk     (clk),
    .rst     (rst),
    .en      (adv),
    .inVld   (inject),
    .inLast  (injLast),
    .inOp0   (injOp0),
    .outVld  (outVld),
    .outLast (outLast),
    .outOp0  (outOp0),
    .anyVld  (anyVld)
  );

  // The address follows the slot counter; only injection cycles matter.
  assign bus.mem_addr       = base + ADDR_W'(slot);
  assign bus.mem_en         = adv;
  assign bus.start_ready    = (state == ST_IDLE);
  assign bus.readyArray_0   = (state == ST_STREAM) & adv;
  assign bus.validArray_0   = outVld;
  assign bus.dataOutArray_0 = outVld ? outOp0 : '0;
  assign bus.dataOutArray_1 = outVld ? bus.mem_rdata : '0;
  assign bus.lastOut        = outLast;
  assign bus.done           = (state == ST_FINISH) & ~anyVld;

endmodule

// File: tb/tb_msdf_feed_seq.sv
// Bench for msdf_feed_seq: a table of jobs (base, input gaps, downstream
// stalls) checked against a slot-sequence model, plus reset-mid-job and a
// minimal-job configuration on a second instance.
module tb_msdf_feed_seq;
  import msdf_feed_pkg::*;

  localparam int DW = 192, AW = 9, PRE = 4, AD = 3, TOT = 25, LAT = 2, LASTC = 4;
  localparam int NJOBS = 5;

  typedef struct {
    logic [AW-1:0]        base;
    int                   gap;        // 0 always valid, 1 every 3rd cycle, 2 random
    bit                   stall;      // random downstream backpressure
    bit                   holdStart;  // keep start_valid high (must be ignored)
    logic [AD-1:0][DW-1:0] din;
    logic [AW-1:0]        firstAddr;
    logic [AW-1:0]        lastAddr;
  } job_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  job_t jobs [NJOBS];

  always #5 clk = ~clk;

  msdf_feed_seq_if #(.DIGIT_W(DW), .ADDR_W(AW)) busA ();
  msdf_feed_seq_if #(.DIGIT_W(DW), .ADDR_W(AW)) busB ();

  msdf_feed_seq #(.DIGIT_W(DW), .ADDR_W(AW), .PRE_DIGITS(PRE), .A_DIGITS(AD),
                  .TOTAL_DIGITS(TOT), .MEM_LAT(LAT), .LAST_CODE(LASTC))
    dutA (.clk(clk), .rst(rst), .bus(busA.slave));

  msdf_feed_seq #(.DIGIT_W(DW), .ADDR_W(AW), .PRE_DIGITS(0), .A_DIGITS(1),
                  .TOTAL_DIGITS(2), .MEM_LAT(LAT), .LAST_CODE(LASTC))
    dutB (.clk(clk), .rst(rst), .bus(busB.slave));

  // Weight memory contents: distinct word per address.
  function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
    logic [31:0] h;
    logic [31:0] ax;
    ax = {23'd0, a};
    h  = ax * 32'h9E3779B1 + 32'h12345678;
    return {h, ~h, h ^ 32'hA5A5A5A5, ax, h, 32'hC0DE0000 | ax};
  endfunction

  // Fixed-latency memories whose output registers advance on mem_en.
  logic [DW-1:0] memA [LAT];
  logic [DW-1:0] memB [LAT];
  always @(posedge clk) begin
    if (busA.mem_en) begin
      memA[0] <= memWord(busA.mem_addr);
      for (int i = 1; i < LAT; i++) memA[i] <= memA[i-1];
    end
    if (busB.mem_en) begin
      memB[0] <= memWord(busB.mem_addr);
      for (int i = 1; i < LAT; i++) memB[i] <= memB[i-1];
    end
  end
  assign busA.mem_rdata = memA[LAT-1];
  assign busB.mem_rdata = memB[LAT-1];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected op0 of slot k from the job's slot layout.
  function automatic logic [DW-1:0] expOp0(input job_t j, input int k);
    if (k < PRE) return '0;
    if (k < PRE + AD) return j.din[k-PRE];
    if (k == TOT - 1) return DW'(LASTC);
    return '0;
  endfunction

  function automatic bit gapOk(input int g, input int cyc);
    if (g == 0) return 1'b1;
    if (g == 1) return (cyc % 3) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic checkResetA(input string tag);
    check({tag, " start_ready"}, busA.start_ready, 1);
    check({tag, " readyArray_0"}, busA.readyArray_0, 0);
    check({tag, " validArray_0"}, busA.validArray_0, 0);
    check({tag, " done"}, busA.done, 0);
    check({tag, " mem_en"}, busA.mem_en, 1);
    check({tag, " lastOut"}, busA.lastOut, 0);
    check({tag, " op0"}, busA.dataOutArray_0, '0);
    check({tag, " op1"}, busA.dataOutArray_1, '0);
  endtask

  // Runs one job on instance A; abortAt >= 0 asserts reset once that many inputs were taken.
  task automatic runJob(input job_t j, input int abortAt);
    int k = 0, inIdx = 0, doneCnt = 0, cyc = 0;
    bit accepted = 0, prevStall = 0, finished = 0;
    logic [DW-1:0] pOp0 = '0, pOp1 = '0, firstOp1 = '0, lastOp1 = '0;
    logic pLast = 1'b0;
    busA.start_valid   = 1'b1;
    busA.start_base    = j.base;
    busA.pValidArray_0 = gapOk(j.gap, 0);
    busA.dataInArray_0 = j.din[0];
    busA.nReadyArray_0 = j.stall ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!finished && cyc < 400) begin
      @(negedge clk);
      if (abortAt >= 0 && accepted && inIdx == abortAt) begin
        rst = 1'b1;
        #1;
        checkResetA("reset mid-job");
        @(negedge clk);
        check("no done during reset", busA.done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        busA.start_valid = 1'b0;
        busA.pValidArray_0 = 1'b0;
        busA.nReadyArray_0 = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (prevStall) begin
        check("held valid", busA.validArray_0, 1);
        check("held op0", busA.dataOutArray_0, pOp0);
        check("held op1", busA.dataOutArray_1, pOp1);
        check("held lastOut", busA.lastOut, pLast);
      end
      if (busA.validArray_0 && busA.nReadyArray_0) begin
        if (k < TOT) begin
          check($sformatf("op0 slot %0d", k), busA.dataOutArray_0, expOp0(j, k));
          check($sformatf("op1 slot %0d", k), busA.dataOutArray_1, memWord(AW'(j.base + AW'(k))));
          check($sformatf("lastOut slot %0d", k), busA.lastOut, (k == TOT - 1));
          if (k == 0) firstOp1 = busA.dataOutArray_1;
          if (k == TOT - 1) lastOp1 = busA.dataOutArray_1;
        end else begin
          check("extra output beyond job", k, TOT - 1);
        end
        k++;
      end
      prevStall = busA.validArray_0 && !busA.nReadyArray_0;
      pOp0 = busA.dataOutArray_0;
      pOp1 = busA.dataOutArray_1;
      pLast = busA.lastOut;
      check("readyArray_0 outside stream", busA.readyArray_0 && (!accepted || inIdx >= AD), 0);
      check("mem_en follows advance", busA.mem_en, !busA.validArray_0 || busA.nReadyArray_0);
      if (accepted) check("start_ready while busy", busA.start_ready, 0);
      if (busA.done) begin
        doneCnt++;
        check("done only after full drain", k, TOT);
        finished = 1;
      end
      if (busA.pValidArray_0 && busA.readyArray_0) inIdx++;
      if (busA.start_valid && busA.start_ready) accepted = 1;
      @(posedge clk); #1;
      cyc++;
      if (accepted && (!j.holdStart || finished)) busA.start_valid = 1'b0;
      if (accepted && j.holdStart) busA.start_base = ~j.base;
      busA.pValidArray_0 = (inIdx < AD) && gapOk(j.gap, cyc);
      busA.dataInArray_0 = (inIdx < AD) ? j.din[inIdx] : {6{$urandom}};
      busA.nReadyArray_0 = j.stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (!finished) check("job timed out waiting for done", 0, 1);
    check("slots delivered", k, TOT);
    check("done pulses", doneCnt, 1);
    check("first weight address", firstOp1, memWord(j.firstAddr));
    check("last weight address", lastOp1, memWord(j.lastAddr));
    busA.pValidArray_0 = 1'b0;
    busA.nReadyArray_0 = 1'b1;
    @(negedge clk);
    check("done is one cycle", busA.done, 0);
    check("start_ready back in idle", busA.start_ready, 1);
    @(posedge clk); #1;
  endtask

  // Minimal job on instance B: one streamed digit then the last marker.
  task automatic runSmallJob(input logic [AW-1:0] base, input logic [DW-1:0] d);
    int kb = 0, doneB = 0;
    bit accepted = 0, taken = 0;
    busB.start_valid   = 1'b1;
    busB.start_base    = base;
    busB.pValidArray_0 = 1'b1;
    busB.dataInArray_0 = d;
    busB.nReadyArray_0 = 1'b1;
    for (int c = 0; c < 30 && doneB == 0; c++) begin
      @(negedge clk);
      if (busB.validArray_0) begin
        check($sformatf("small op0 slot %0d", kb), busB.dataOutArray_0, (kb == 0) ? d : DW'(LASTC));
        check($sformatf("small op1 slot %0d", kb), busB.dataOutArray_1, memWord(AW'(base + AW'(kb))));
        check($sformatf("small lastOut slot %0d", kb), busB.lastOut, (kb == 1));
        kb++;
      end
      if (busB.done) begin
        doneB++;
        check("small done after drain", kb, 2);
      end
      if (busB.start_valid && busB.start_ready) accepted = 1;
      if (busB.pValidArray_0 && busB.readyArray_0) taken = 1;
      @(posedge clk); #1;
      if (accepted) busB.start_valid = 1'b0;
      if (taken) busB.pValidArray_0 = 1'b0;
    end
    check("small slots delivered", kb, 2);
    check("small done pulses", doneB, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    jobs[0] = '{base: 9'd0,   gap: 0, stall: 1'b0, holdStart: 1'b0, din: '0, firstAddr: 9'd0,   lastAddr: 9'd24};
    jobs[1] = '{base: 9'd100, gap: 1, stall: 1'b0, holdStart: 1'b0, din: '0, firstAddr: 9'd100, lastAddr: 9'd124};
    jobs[2] = '{base: 9'd37,  gap: 0, stall: 1'b1, holdStart: 1'b1, din: '0, firstAddr: 9'd37,  lastAddr: 9'd61};
    jobs[3] = '{base: 9'd510, gap: 1, stall: 1'b1, holdStart: 1'b0, din: '0, firstAddr: 9'd510, lastAddr: 9'd22};
    jobs[4] = '{base: 9'd490, gap: 2, stall: 1'b1, holdStart: 1'b1, din: '0, firstAddr: 9'd490, lastAddr: 9'd2};
    jobs[0].din[0] = DW'(1);
    jobs[0].din[1] = DW'(2);
    jobs[0].din[2] = DW'(3);
    for (int n = 1; n < NJOBS; n++)
      for (int d = 0; d < AD; d++)
        for (int w = 0; w < 6; w++) jobs[n].din[d][w*32 +: 32] = $urandom;

    rst = 1'b1;
    busA.start_valid = 1'b0; busA.start_base = '0; busA.pValidArray_0 = 1'b0;
    busA.dataInArray_0 = '0; busA.nReadyArray_0 = 1'b1;
    busB.start_valid = 1'b0; busB.start_base = '0; busB.pValidArray_0 = 1'b0;
    busB.dataInArray_0 = '0; busB.nReadyArray_0 = 1'b1;
    #1;
    checkResetA("reset");
    check("reset B validArray_0", busB.validArray_0, 0);
    check("reset B start_ready", busB.start_ready, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < NJOBS; n++) runJob(jobs[n], -1);
    runJob(jobs[0], 2);
    runJob(jobs[0], -1);
    runSmallJob(9'd7, {6{32'hDEADBEEF}});
    runSmallJob(9'd511, DW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
